mlu_serial_ctrl: RTL and testbench

Nibble-serial sequencer for the MLU: accepts one WIDTH-bit MLU operation over a valid/ready handshake and drives a single 4-bit `mlu_slice` for WIDTH/4 consecutive cycles, least-significant nibble first. Each cycle it chains the carry from the slice's generate/propagate outputs, assembles the result and accumulates the zero flag. It sits between instruction decode and the register-file writeback as the area-minimal ALU option, trading latency for one slice instead of WIDTH/4.

---
 rtl/common.sv | 24 ++
 rtl/mlu_slice.sv | 40 ++++
 rtl/mlu_serial_ctrl.sv | 157 +++++++++++++++
 tb/tb_mlu_serial_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared MLU definitions: opcodes, serial sequencer states and the carry-chain equation.
package common;

    localparam logic [2:0] MLU_ADD  = 3'd0;
    localparam logic [2:0] MLU_SUB  = 3'd1;
    localparam logic [2:0] MLU_AND  = 3'd2;
    localparam logic [2:0] MLU_OR   = 3'd3;
    localparam logic [2:0] MLU_XOR  = 3'd4;
    localparam logic [2:0] MLU_NOT  = 3'd5;
    localparam logic [2:0] MLU_NOP0 = 3'd6;
    localparam logic [2:0] MLU_NOP1 = 3'd7;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } mlu_serial_state_t;

    // Carry out of a nibble group from its generate/propagate pair.
    function automatic logic mlu_carry(input logic gen, input logic prop, input logic c_in);
        return gen | (prop & c_in);
    endfunction

endpackage

// File: rtl/mlu_slice.sv
// 4-bit MLU slice: nibble result plus zero, generate and propagate flags.
module mlu_slice
    import common::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [2:0] op_i,
    input  logic       c_in_i,
    output logic [7:0] out_o
);

    logic [4:0] sum;
    logic [3:0] nib;
    logic       gen;
    logic       prop;

    // Arithmetic ops report gen/prop of a+b (b inverted for SUB); logic ops report none.
    always_comb begin
        sum  = 5'd0;
        nib  = 4'd0;
        gen  = 1'b0;
        prop = 1'b0;
        unique case (op_i)
            MLU_ADD, MLU_SUB: begin
                sum  = {1'b0, a_i} + {1'b0, (op_i == MLU_SUB) ? ~b_i : b_i};
                gen  = sum[4];
                prop = (sum[3:0] == 4'hF);
                nib  = sum[3:0] + {3'd0, c_in_i};
            end
            MLU_AND: nib = a_i & b_i;
            MLU_OR:  nib = a_i | b_i;
            MLU_XOR: nib = a_i ^ b_i;
            MLU_NOT: nib = ~a_i;
            default: nib = 4'd0;
        endcase
    end

    assign out_o = {1'b0, (nib == 4'd0), gen, prop, nib};

endmodule

// File: rtl/mlu_serial_ctrl.sv
// Nibble-serial MLU sequencer: drives one external mlu_slice for WIDTH/4 cycles, LSB first.
module mlu_serial_ctrl
    import common::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             N_RST,
    input  logic             N_BOOTED,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [WIDTH-1:0] REQ_A,
    input  logic [WIDTH-1:0] REQ_B,
    input  logic [2:0]       REQ_OP,
    output logic             RESP_VALID,
    input  logic             RESP_READY,
    output logic [WIDTH-1:0] RESP_OUT,
    output logic             RESP_CARRY,
    output logic             RESP_ZERO,
    output logic [3:0]       SLICE_A,
    output logic [3:0]       SLICE_B,
    output logic [2:0]       SLICE_OP,
    output logic             SLICE_C_IN,
    input  logic [7:0]       SLICE_OUT
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    mlu_serial_state_t state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [2:0]        op_q, op_d;

    logic [IdxW+1:0]   nib_sh;
    logic [WIDTH-1:0]  nib_mask;
    logic              in_run;
    logic              unused_slice_msb;

    assign unused_slice_msb = SLICE_OUT[7];
    assign nib_sh   = {idx_q, 2'b00};
    assign nib_mask = WIDTH'(4'hF) << nib_sh;
    assign in_run   = (state_q == StRun);

    // Ready is forced low during reset since the state register already reads as idle.
    assign REQ_READY  = N_RST && (state_q == StIdle) && !N_BOOTED;
    assign RESP_VALID = (state_q == StDone);
    assign RESP_OUT   = RESP_VALID ? result_q : '0;
    assign RESP_CARRY = RESP_VALID & carry_q;
    assign RESP_ZERO  = RESP_VALID & zero_q;

    // Slice drive: current nibble only while running; opcode always reflects the latched op.
    always_comb begin
        SLICE_A    = 4'd0;
        SLICE_B    = 4'd0;
        SLICE_C_IN = 1'b0;
        SLICE_OP   = op_q;
        if (in_run) begin
            SLICE_A    = 4'(a_q >> nib_sh);
            SLICE_B    = 4'(b_q >> nib_sh);
            SLICE_C_IN = carry_q;
        end
    end

    // Next-state: accept, per-nibble capture with carry chaining, and response hold.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        result_d = result_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        unique case (state_q)
            StIdle: begin
                if (REQ_VALID && REQ_READY) begin
                    a_d     = REQ_A;
                    b_d     = REQ_B;
                    op_d    = REQ_OP;
                    idx_d   = '0;
                    zero_d  = 1'b1;
                    carry_d = (REQ_OP == MLU_SUB);
                    state_d = StRun;
                end
            end
            StRun: begin
                result_d = (result_q & ~nib_mask) | (WIDTH'(SLICE_OUT[3:0]) << nib_sh);
                carry_d  = mlu_carry(SLICE_OUT[5], SLICE_OUT[4], carry_q);
                zero_d   = zero_q & SLICE_OUT[6];
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (RESP_READY) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 3'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            result_q <= result_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
        end
    end

`ifdef FORMAL
    function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            MLU_ADD: return a + b;
            MLU_SUB: return a - b;
            MLU_AND: return a & b;
            MLU_OR:  return a | b;
            MLU_XOR: return a ^ b;
            MLU_NOT: return ~a;
            default: return '0;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (N_RST) begin
            if (RESP_VALID) assert (RESP_OUT == ref_op(op_q, a_q, b_q));
            if (RESP_VALID) assert (RESP_ZERO == (RESP_OUT == '0));
            assert (!(REQ_READY && RESP_VALID));
        end
    end
`endif

endmodule

// File: tb/tb_mlu_serial_ctrl.sv
// Directed self-checking bench for mlu_serial_ctrl paired with mlu_slice.
module tb_mlu_serial_ctrl;
    import common::*;

    logic        CLK = 1'b0;
    logic        N_RST = 1'b0;
    logic        N_BOOTED = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [31:0] REQ_A = '0;
    logic [31:0] REQ_B = '0;
    logic [2:0]  REQ_OP = 3'd0;
    logic        RESP_VALID;
    logic        RESP_READY = 1'b0;
    logic [31:0] RESP_OUT;
    logic        RESP_CARRY;
    logic        RESP_ZERO;
    logic [3:0]  SLICE_A;
    logic [3:0]  SLICE_B;
    logic [2:0]  SLICE_OP;
    logic        SLICE_C_IN;
    logic [7:0]  SLICE_OUT;

    int n_checks = 0;
    int n_fail   = 0;
    bit busy     = 1'b0;

    always #5 CLK = ~CLK;

    mlu_serial_ctrl #(.WIDTH(32)) dut (
        .CLK(CLK), .N_RST(N_RST), .N_BOOTED(N_BOOTED),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_OP(REQ_OP),
        .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY),
        .RESP_OUT(RESP_OUT), .RESP_CARRY(RESP_CARRY), .RESP_ZERO(RESP_ZERO),
        .SLICE_A(SLICE_A), .SLICE_B(SLICE_B), .SLICE_OP(SLICE_OP),
        .SLICE_C_IN(SLICE_C_IN), .SLICE_OUT(SLICE_OUT)
    );

    mlu_slice u_slice (
        .a_i(SLICE_A), .b_i(SLICE_B), .op_i(SLICE_OP), .c_in_i(SLICE_C_IN), .out_o(SLICE_OUT)
    );

    // Bootstrap status must not change while an operation is in flight.
    always @(posedge CLK) begin
        if (busy) assert (!N_BOOTED) else $error("FAIL boot_in_flight: N_BOOTED=1 while busy");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Wait from just after the accept edge until RESP_VALID; lat counts edges.
    task automatic wait_resp(output int lat);
        lat = 0;
        while (!RESP_VALID && lat < 40) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        if (!RESP_VALID) check_eq("resp_timeout", 32'd0, 32'd1);
    endtask

    // Present a request, wait for its accept edge, then wait for the response.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        bit got = 1'b0;
        @(negedge CLK);
        REQ_OP = op; REQ_A = a; REQ_B = b; REQ_VALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (REQ_READY) begin
                got = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (!got) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            REQ_VALID = 1'b0;
            lat = -1;
        end else begin
            @(posedge CLK);
            #1;
            REQ_VALID = 1'b0;
            busy = 1'b1;
            wait_resp(lat);
        end
    endtask

    task automatic release_resp();
        RESP_READY = 1'b1;
        @(posedge CLK);
        #1;
        RESP_READY = 1'b0;
        busy = 1'b0;
        check_eq("idle_resp_valid", 32'(RESP_VALID), 32'd0);
        check_eq("idle_req_ready", 32'(REQ_READY), 32'd1);
    endtask

    task automatic run_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] e_out, input logic e_c,
                             input logic e_z);
        int lat;
        issue(op, a, b, lat);
        check_eq({tag, "_lat"}, 32'(lat), 32'd8);
        check_eq({tag, "_out"}, RESP_OUT, e_out);
        check_eq({tag, "_carry"}, 32'(RESP_CARRY), 32'(e_c));
        check_eq({tag, "_zero"}, 32'(RESP_ZERO), 32'(e_z));
        release_resp();
    endtask

    initial begin
        int  lat;
        bit  stable;
        bit  any_ready;

        // Reset values
        #2;
        check_eq("rst_req_ready", 32'(REQ_READY), 32'd0);
        check_eq("rst_resp_valid", 32'(RESP_VALID), 32'd0);
        check_eq("rst_resp_out", RESP_OUT, 32'd0);
        check_eq("rst_resp_flags", {30'd0, RESP_CARRY, RESP_ZERO}, 32'd0);
        check_eq("rst_slice", {20'd0, SLICE_A, SLICE_B, SLICE_OP, SLICE_C_IN}, 32'd0);
        @(negedge CLK);
        N_RST = 1'b1;
        @(negedge CLK);
        check_eq("post_rst_ready", 32'(REQ_READY), 32'd1);

        run_check("add_wrap", MLU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b1, 1'b1);
        run_check("sub_borrow", MLU_SUB, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_check("sub_pos", MLU_SUB, 32'h7, 32'h5, 32'h2, 1'b1, 1'b0);
        run_check("xor_self", MLU_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b1);
        run_check("not", MLU_NOT, 32'h0F0F_0F0F, 32'h0, 32'hF0F0_F0F0, 1'b0, 1'b0);
        run_check("and", MLU_AND, 32'hFF00_F0F0, 32'h0FF0_3C3C, 32'h0F00_3030, 1'b0, 1'b0);
        run_check("or", MLU_OR, 32'h1200_0034, 32'h0056_7800, 32'h1256_7834, 1'b0, 1'b0);
        run_check("nop1", MLU_NOP1, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 1'b0, 1'b1);

        // Response held with RESP_READY low
        issue(MLU_ADD, 32'h1234_5678, 32'h1111_1111, lat);
        check_eq("hold_lat", 32'(lat), 32'd8);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            if (RESP_OUT !== 32'h2345_6789 || !RESP_VALID || REQ_READY || RESP_CARRY || RESP_ZERO)
                stable = 1'b0;
        end
        check_eq("hold_stable", 32'(stable), 32'd1);
        release_resp();

        // Not booted: no accept until N_BOOTED falls
        N_BOOTED = 1'b1;
        REQ_OP = MLU_ADD; REQ_A = 32'h3; REQ_B = 32'h4; REQ_VALID = 1'b1;
        any_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (REQ_READY || RESP_VALID) any_ready = 1'b1;
        end
        check_eq("boot_blocked", 32'(any_ready), 32'd0);
        @(posedge CLK);
        #1;
        N_BOOTED = 1'b0;
        @(negedge CLK);
        check_eq("boot_ready", 32'(REQ_READY), 32'd1);
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        busy = 1'b1;
        check_eq("boot_accepted", 32'(REQ_READY), 32'd0);
        wait_resp(lat);
        check_eq("boot_lat", 32'(lat), 32'd8);
        check_eq("boot_out", RESP_OUT, 32'h7);
        release_resp();

        // Asynchronous reset in the middle of a run
        @(negedge CLK);
        REQ_OP = MLU_ADD; REQ_A = 32'h0000_3000; REQ_B = 32'h0000_0500; REQ_VALID = 1'b1;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        busy = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("mid_run_slice_a", 32'(SLICE_A), 32'd3);
        N_RST = 1'b0;
        busy = 1'b0;
        #1;
        check_eq("abort_valid_ready", {30'd0, RESP_VALID, REQ_READY}, 32'd0);
        check_eq("abort_out", RESP_OUT, 32'd0);
        check_eq("abort_slice", {20'd0, SLICE_A, SLICE_B, SLICE_OP, SLICE_C_IN}, 32'd0);
        repeat (2) @(negedge CLK);
        N_RST = 1'b1;
        run_check("post_abort_add", MLU_ADD, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
